id_ex_stage: RTL
================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port id_valid  input  1  decode stage holds a real instruction.
REQ-004 SHALL have port id_opcode  input  7  decoded opcode.
REQ-005 SHALL have ports id_rsrc1, id_rsrc2, id_rdst  input  3 each  source/destination register indices.
REQ-006 SHALL have port id_imm  input  16  immediate/offset.
REQ-007 SHALL have ports id_load, id_wb  input  1 each  instruction reads memory / writes register file.
REQ-008 SHALL have port stallD  input  1  load-use stall request from hazard logic.
REQ-009 SHALL have port flushE  input  1  squash instruction entering execute (taken branch/jump).
REQ-010 SHALL have port hold  input  1  downstream busy; freeze stage.
REQ-011 SHALL have port err_clr  input  1  clears sticky error flag.
REQ-012 SHALL have ports ex_valid, ex_load, ex_wb  output  1 each  registered execute-stage control.
REQ-013 SHALL have ports ex_opcode (7), ex_rsrc1/ex_rsrc2/ex_rdst (3), ex_imm (16)  output  registered execute-stage fields.
REQ-014 SHALL have port id_ready  output  1  decode may advance this cycle.
REQ-015 SHALL have ports stall_cnt, flush_cnt  output  16 each  saturating event counters.
REQ-016 SHALL have port err_stall  output  1  sticky protocol-error flag.

Function
REQ-017 SHALL evaluate per rising edge with priority hold > flushE > stallD > normal advance.
REQ-018 hold=1 SHALL retain every register, counter and err_stall unchanged (err_clr still honoured).
REQ-019 flushE=1 (hold=0) SHALL load bubble: ex_valid, ex_load, ex_wb = 0, all ex_ field registers = 0; flush_cnt +1.
REQ-020 stallD=1 (hold=0, flushE=0) SHALL load the same bubble as REQ-019; stall_cnt +1.
REQ-021 Normal advance SHALL capture all id_ fields; ex_valid = id_valid, ex_load = id_valid & id_load, ex_wb = id_valid & id_wb.
REQ-022 id_valid=0 on advance SHALL still capture fields but force ex_valid/ex_load/ex_wb = 0.
REQ-023 id_ready SHALL be combinational: ~hold & ~stallD (flushE does not deassert it).
REQ-024 Latency SHALL be exactly one cycle from id_ inputs to ex_ outputs on advance.
REQ-025 Counters SHALL saturate at 16'hFFFF; no wrap to 0.
REQ-026 flushE and stallD together SHALL increment flush_cnt only.
REQ-027 err_stall SHALL set on an edge where hold=0, flushE=0, stallD=1 and (ex_valid=0 or ex_load=0) -- stall without a valid load in execute.
REQ-028 err_clr=1 SHALL clear err_stall next edge; simultaneous set condition SHALL win (flag stays 1).
REQ-029 A correct load-use stall SHALL last one cycle: bubble clears ex_load, so a repeated stallD the next cycle flags err_stall.

Reset
REQ-030 rst_n=0 SHALL immediately, without clock, force ex_valid, ex_load, ex_wb, all ex_ fields, stall_cnt, flush_cnt, err_stall to 0.
REQ-031 Reset asserted mid-stall or mid-hold SHALL discard the in-flight instruction; first edge after release performs normal priority evaluation.

Verification
REQ-032 Advance: id_valid=1, opcode 7'b1010000, rdst=3, id_load=1 -> next cycle ex_valid=1, ex_load=1, ex_rdst=3, ex_opcode=7'b1010000.
REQ-033 Load-use: previous state, then stallD=1 one cycle -> id_ready=0 that cycle, next cycle ex_valid=0, ex_load=0, stall_cnt=1, err_stall=0.
REQ-034 Priority: stallD=1, flushE=1 same cycle -> bubble, flush_cnt=1, stall_cnt unchanged; with hold=1 added -> nothing changes.
REQ-035 Error: stallD=1 two consecutive cycles -> err_stall=1 after second edge; err_clr pulse -> err_stall=0.
REQ-036 Saturation: 65 537 stall cycles (ex_load held via preload each time) -> stall_cnt=16'hFFFF, no wrap.
REQ-037 Async reset: rst_n low between edges with ex_valid=1 -> ex_valid=0 and counters 0 before next clk edge.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded fields into the execute stage,
// inserting bubbles on flush/stall, with saturating event counters and a sticky stall-protocol flag.
module id_ex_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [6:0]  id_opcode,
    input  logic [2:0]  id_rsrc1,
    input  logic [2:0]  id_rsrc2,
    input  logic [2:0]  id_rdst,
    input  logic [15:0] id_imm,
    input  logic        id_load,
    input  logic        id_wb,
    input  logic        stallD,
    input  logic        flushE,
    input  logic        hold,
    input  logic        err_clr,
    output logic        ex_valid,
    output logic        ex_load,
    output logic        ex_wb,
    output logic [6:0]  ex_opcode,
    output logic [2:0]  ex_rsrc1,
    output logic [2:0]  ex_rsrc2,
    output logic [2:0]  ex_rdst,
    output logic [15:0] ex_imm,
    output logic        id_ready,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt,
    output logic        err_stall
);

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    logic err_set;

    // Flush does not block decode: the squashed slot is simply overwritten by a bubble.
    assign id_ready = ~hold & ~stallD;

    // A legitimate load-use stall only happens while a valid load sits in execute.
    assign err_set = ~hold & ~flushE & stallD & ~(ex_valid & ex_load);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, regardless of statement order in the block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid  <= 1'b0;
            ex_load   <= 1'b0;
            ex_wb     <= 1'b0;
            ex_opcode <= '0;
            ex_rsrc1  <= '0;
            ex_rsrc2  <= '0;
            ex_rdst   <= '0;
            ex_imm    <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
            err_stall <= 1'b0;
        end else begin
            if (!hold) begin
                if (flushE || stallD) begin
                    ex_valid  <= 1'b0;
                    ex_load   <= 1'b0;
                    ex_wb     <= 1'b0;
                    ex_opcode <= '0;
                    ex_rsrc1  <= '0;
                    ex_rsrc2  <= '0;
                    ex_rdst   <= '0;
                    ex_imm    <= '0;
                    if (flushE) begin
                        if (flush_cnt != CNT_MAX) flush_cnt <= flush_cnt + 16'd1;
                    end else begin
                        if (stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + 16'd1;
                    end
                end else begin
                    ex_valid  <= id_valid;
                    ex_load   <= id_valid & id_load;
                    ex_wb     <= id_valid & id_wb;
                    ex_opcode <= id_opcode;
                    ex_rsrc1  <= id_rsrc1;
                    ex_rsrc2  <= id_rsrc2;
                    ex_rdst   <= id_rdst;
                    ex_imm    <= id_imm;
                end
            end

            // A new violation on the same edge outranks the clear request.
            if (err_set) begin
                err_stall <= 1'b1;
            end else if (err_clr) begin
                err_stall <= 1'b0;
            end
        end
    end

endmodule
